// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for register_ctrl: default widths, opcode values and FSM state encoding.
package reg_ctrl_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_OP_W   = 4;

  localparam logic [DEF_OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [DEF_OP_W-1:0] OP_CLR  = 4'd1;
  localparam logic [DEF_OP_W-1:0] OP_LOAD = 4'd2;
  localparam logic [DEF_OP_W-1:0] OP_INC  = 4'd3;
  localparam logic [DEF_OP_W-1:0] OP_DEC  = 4'd4;
  localparam logic [DEF_OP_W-1:0] OP_SHR  = 4'd5;
  localparam logic [DEF_OP_W-1:0] OP_SHL  = 4'd6;
  localparam logic [DEF_OP_W-1:0] OP_ROR  = 4'd7;
  localparam logic [DEF_OP_W-1:0] OP_ROL  = 4'd8;
  localparam logic [DEF_OP_W-1:0] OP_ASR  = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/register_ctrl.sv
// Command sequencer that expands opcode/count commands into strobes for a 4-bit register.
// Optional REG_CTRL_ABORT_EN adds an abort input and an aborted pulse output.
module register_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_arg,
  input  logic [DATA_W-1:0] reg_q,
  output logic              cl,
  output logic              ld,
  output logic [DATA_W-1:0] ld_data,
  output logic              inc,
  output logic              dec,
  output logic              sr,
  output logic              ir,
  output logic              sl,
  output logic              il,
  output logic              done,
`ifdef REG_CTRL_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              err
);

  state_t              state;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   arg_q;
  logic [DATA_W-1:0]   count;
  logic [DATA_W-1:0]   count_n;
  logic                err_q;
  logic                op_legal;
  logic                last;
  logic                active;
  logic                abort_hit;
  logic                reg_q_unused;

`ifdef REG_CTRL_ABORT_EN
  assign abort_hit = abort && (state == ST_EXEC);
  assign aborted   = abort_hit;
`else
  assign abort_hit = 1'b0;
`endif

  // Handshake: a command transfers on any cycle where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so the source must hold its command until then.
  assign cmd_ready = (state == ST_IDLE);
  assign op_legal  = (cmd_op <= OP_ASR);
  assign last      = (state == ST_EXEC) && (count <= DATA_W'(1)) && !abort_hit;
  assign active    = (state == ST_EXEC) && (count != '0) && !abort_hit;
  assign done      = last;
  assign err       = err_q;
  assign ld_data   = arg_q;
  assign reg_q_unused = ^reg_q[DATA_W-2:1];

  always_comb begin
    count_n = '0;
    case (cmd_op)
      OP_CLR, OP_LOAD: count_n = DATA_W'(1);
      OP_INC, OP_DEC, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_ASR: count_n = cmd_arg;
      default: count_n = '0;
    endcase
  end

  // Fill bits follow live reg_q so each step sees the previous strobe's result.
  always_comb begin
    cl  = 1'b0;
    ld  = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    sr  = 1'b0;
    ir  = 1'b0;
    sl  = 1'b0;
    il  = 1'b0;
    if (active) begin
      case (op_q)
        OP_CLR:  cl = 1'b1;
        OP_LOAD: ld = 1'b1;
        OP_INC:  inc = 1'b1;
        OP_DEC:  dec = 1'b1;
        OP_SHR:  sr = 1'b1;
        OP_SHL:  sl = 1'b1;
        OP_ROR:  begin sr = 1'b1; ir = reg_q[0];        end
        OP_ROL:  begin sl = 1'b1; il = reg_q[DATA_W-1]; end
        OP_ASR:  begin sr = 1'b1; ir = reg_q[DATA_W-1]; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_q  <= '0;
      arg_q <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            arg_q <= cmd_arg;
            if (op_legal) begin
              count <= count_n;
              state <= ST_EXEC;
            end else begin
              count <= '0;
              err_q <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (count != '0) count <= count - DATA_W'(1);
          if (last || abort_hit) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_ctrl.sv
// Directed plus random bench for register_ctrl driving a behavioural 4-bit register.
module tb_register_ctrl;

  localparam int VW = 19;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'h0;
  logic [3:0] cmd_arg = 4'h0;
  logic [3:0] reg_q = 4'h0;
  logic       cl, ld, inc, dec, sr, ir, sl, il, done, err;
  logic [3:0] ld_data;
`ifdef REG_CTRL_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [VW-1:0] exp_q[$];
  logic [3:0] m_reg = 4'h0;
  logic [3:0] m_arg = 4'h0;

  register_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .reg_q(reg_q),
    .cl(cl), .ld(ld), .ld_data(ld_data), .inc(inc), .dec(dec),
    .sr(sr), .ir(ir), .sl(sl), .il(il), .done(done),
`ifdef REG_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  // Behavioural downstream register
  always @(posedge clk) begin
    if (cl)       reg_q <= 4'h0;
    else if (ld)  reg_q <= ld_data;
    else if (inc) reg_q <= reg_q + 4'h1;
    else if (dec) reg_q <= reg_q - 4'h1;
    else if (sr)  reg_q <= {ir, reg_q[3:1]};
    else if (sl)  reg_q <= {reg_q[2:0], il};
  end

  function automatic logic [VW-1:0] obs();
    return {cmd_ready, cl, ld, inc, dec, sr, ir, sl, il, done, err, ld_data, reg_q};
  endfunction

  // st = {cl, ld, inc, dec, sr, sl}
  function automatic logic [VW-1:0] mk(logic rdy, logic [5:0] st, logic fir, logic fil,
                                        logic dn, logic er, logic [3:0] ldd, logic [3:0] q);
    return {rdy, st[5:1], fir, st[0], fil, dn, er, ldd, q};
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] o, input logic [VW-1:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // driver: entered just after a rising edge in cycle A; leaves in the IDLE cycle after completion
  task automatic send(input string tag, input logic [3:0] op, input logic [3:0] arg,
                      input logic hold, input logic [3:0] hold_op, input logic [3:0] hold_arg);
    logic [5:0] st;
    logic       fir, fil;
    logic [3:0] nx;
    int         n, m;
    bit         first;
    n = (op == 4'd1 || op == 4'd2) ? 1 : (op == 4'd0 ? 0 : int'(arg));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    exp_q.push_back(mk(1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_arg, m_reg));
    m_arg = arg;
    if (op > 4'd9) begin
      exp_q.push_back(mk(1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_arg, m_reg));
    end else begin
      m = (n == 0) ? 1 : n;
      for (int k = 1; k <= m; k++) begin
        st = 6'b0; fir = 1'b0; fil = 1'b0; nx = m_reg;
        if (n != 0) begin
          case (op)
            4'd1: begin st = 6'b100000; nx = 4'h0; end
            4'd2: begin st = 6'b010000; nx = arg; end
            4'd3: begin st = 6'b001000; nx = m_reg + 4'h1; end
            4'd4: begin st = 6'b000100; nx = m_reg - 4'h1; end
            4'd5: begin st = 6'b000010; nx = {1'b0, m_reg[3:1]}; end
            4'd6: begin st = 6'b000001; nx = {m_reg[2:0], 1'b0}; end
            4'd7: begin st = 6'b000010; fir = m_reg[0]; nx = {m_reg[0], m_reg[3:1]}; end
            4'd8: begin st = 6'b000001; fil = m_reg[3]; nx = {m_reg[2:0], m_reg[3]}; end
            default: begin st = 6'b000010; fir = m_reg[3]; nx = {m_reg[3], m_reg[3:1]}; end
          endcase
        end
        exp_q.push_back(mk(1'b0, st, fir, fil, k == m, 1'b0, m_arg, m_reg));
        m_reg = nx;
      end
    end
    first = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      chk(tag, obs(), exp_q.pop_front());
      @(posedge clk); #1;
      if (first) begin
        cmd_valid = hold;
        cmd_op    = hold_op;
        cmd_arg   = hold_arg;
        first     = 1'b0;
      end
    end
  endtask

  initial begin
    logic [3:0] rop, rarg;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", obs(), mk(1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send("load_a",   4'd2, 4'hA, 1'b0, 4'h0, 4'h0);
    send("load_9",   4'd2, 4'h9, 1'b0, 4'h0, 4'h0);
    send("ror_2",    4'd7, 4'h2, 1'b0, 4'h0, 4'h0);
    send("load_f",   4'd2, 4'hF, 1'b0, 4'h0, 4'h0);
    send("inc_3",    4'd3, 4'h3, 1'b0, 4'h0, 4'h0);
    send("inc_0",    4'd3, 4'h0, 1'b0, 4'h0, 4'h0);
    send("illegal",  4'hC, 4'h5, 1'b0, 4'h0, 4'h0);
    send("nop",      4'd0, 4'h7, 1'b0, 4'h0, 4'h0);
    send("clr",      4'd1, 4'h3, 1'b0, 4'h0, 4'h0);
    send("load_8",   4'd2, 4'h8, 1'b0, 4'h0, 4'h0);
    send("asr_bp",   4'd9, 4'h2, 1'b1, 4'd6, 4'h1);
    send("shl_held", 4'd6, 4'h1, 1'b0, 4'h0, 4'h0);
    send("rol_3",    4'd8, 4'h3, 1'b0, 4'h0, 4'h0);
    send("shr_2",    4'd5, 4'h2, 1'b0, 4'h0, 4'h0);
    send("dec_2",    4'd4, 4'h2, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      rop  = 4'($urandom_range(0, 15));
      rarg = 4'($urandom_range(0, 4));
      send("random", rop, rarg, 1'b0, 4'h0, 4'h0);
    end

    // reset in the middle of DEC N=5: only one dec lands
    send("load_6", 4'd2, 4'h6, 1'b0, 4'h0, 4'h0);
    cmd_valid = 1'b1; cmd_op = 4'd4; cmd_arg = 4'h5;
    @(negedge clk);
    chk("rst_mid_idle", obs(), mk(1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_arg, m_reg));
    m_arg = 4'h5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_dec1", obs(), mk(1'b0, 6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, m_arg, m_reg));
    m_reg = m_reg - 4'h1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_dec2", obs(), mk(1'b0, 6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, m_arg, m_reg));
    #1 rst_n = 1'b0;
    #1;
    m_arg = 4'h0;
    chk("rst_mid_drop", obs(), mk(1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_arg, m_reg));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send("after_rst", 4'd3, 4'h1, 1'b0, 4'h0, 4'h0);

`ifdef REG_CTRL_ABORT_EN
    cmd_valid = 1'b1; cmd_op = 4'd4; cmd_arg = 4'h5;
    @(negedge clk);
    chk("abort_idle", obs(), mk(1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_arg, m_reg));
    m_arg = 4'h5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_dec1", obs(), mk(1'b0, 6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, m_arg, m_reg));
    m_reg = m_reg - 4'h1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_cycle", obs(), mk(1'b0, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_arg, m_reg));
    chk("aborted_hi", {18'b0, aborted}, 19'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle_after", obs(), mk(1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_arg, m_reg));
    chk("aborted_lo", {18'b0, aborted}, 19'd0);
    @(posedge clk); #1;
    send("post_abort", 4'd2, 4'h3, 1'b0, 4'h0, 4'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
